// File: rtl/hog_bin_pipe.sv
// hog_bin_pipe: turns signed gradient pairs (gx, gy) into a magnitude and an
// orientation bin for the HOG cell-histogram accumulator.
//
// The pipeline has three registered stages and valid/ready flow control.
// Every stage holds its contents while the output is stalled, and sustained
// throughput is one beat per clock.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   grad_valid/ready  input handshake for one gradient pair
//   gx, gy            signed gradient components (DATA_WIDTH+1 bits)
//   signed_mode       0: 9 bins over 0-180 deg, 1: 18 bins over 0-360 deg
//   vote_valid/ready  output handshake
//   magnitude         saturated magnitude (L1, or max + min/2)
//   bin               orientation bin
//   col, row          raster position of the presented beat
//   sof, eol          first beat of the frame / last beat of a line
module hog_bin_pipe #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned MAG_WIDTH   = 8,
    parameter int unsigned MAG_MODE    = 0,
    parameter int unsigned GRID_WIDTH  = 638,
    parameter int unsigned GRID_HEIGHT = 478,
    localparam int unsigned COL_W = (GRID_WIDTH  > 1) ? $clog2(GRID_WIDTH)  : 1,
    localparam int unsigned ROW_W = (GRID_HEIGHT > 1) ? $clog2(GRID_HEIGHT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  grad_valid,
    output logic                  grad_ready,
    input  logic [DATA_WIDTH:0]   gx,
    input  logic [DATA_WIDTH:0]   gy,
    input  logic                  signed_mode,
    output logic                  vote_valid,
    input  logic                  vote_ready,
    output logic [MAG_WIDTH-1:0]  magnitude,
    output logic [4:0]            bin,
    output logic [COL_W-1:0]      col,
    output logic [ROW_W-1:0]      row,
    output logic                  sof,
    output logic                  eol
);

    localparam int unsigned RAW_W  = DATA_WIDTH + 1;
    localparam int unsigned PROD_W = DATA_WIDTH + 11;
    localparam int unsigned SAT_W  = (RAW_W > MAG_WIDTH) ? RAW_W : MAG_WIDTH;
    // tan(20/40/60/80 deg) in Q8
    localparam logic [10:0] TAN_Q8 [4] = '{11'd93, 11'd215, 11'd443, 11'd1452};

    typedef enum logic [1:0] {Q_I, Q_II, Q_III, Q_IV} quad_t;

    logic stall, advance, accept;
    assign stall      = vote_valid && !vote_ready;
    assign advance    = !stall;
    assign grad_ready = !stall;
    assign accept     = grad_valid && grad_ready;

    // Absolute value; the most negative input has no positive twin and clips.
    function automatic logic [DATA_WIDTH-1:0] sat_abs(input logic [DATA_WIDTH:0] v);
        logic [DATA_WIDTH:0] neg;
        neg = ~v + 1'b1;
        if (!v[DATA_WIDTH])     return v[DATA_WIDTH-1:0];
        else if (neg[DATA_WIDTH]) return '1;
        else                      return neg[DATA_WIDTH-1:0];
    endfunction

    // Input-side raster position; tagged onto each accepted beat.
    logic [COL_W-1:0] pos_col;
    logic [ROW_W-1:0] pos_row;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_col <= '0;
            pos_row <= '0;
        end else if (accept) begin
            if (pos_col == COL_W'(GRID_WIDTH - 1)) begin
                pos_col <= '0;
                pos_row <= (pos_row == ROW_W'(GRID_HEIGHT - 1)) ? '0 : pos_row + 1'b1;
            end else begin
                pos_col <= pos_col + 1'b1;
            end
        end
    end

    // Stage 1: absolute values and quadrant.
    quad_t quad_in;
    always_comb begin
        quad_in = Q_I;
        if (gy == '0)           quad_in = gx[DATA_WIDTH] ? Q_III : Q_I;
        else if (!gy[DATA_WIDTH]) quad_in = gx[DATA_WIDTH] ? Q_II  : Q_I;
        else                    quad_in = gx[DATA_WIDTH] ? Q_III : Q_IV;
    end

    logic                  s1_valid, s1_smode;
    logic [DATA_WIDTH-1:0] s1_ax, s1_ay;
    quad_t                 s1_quad;
    logic [COL_W-1:0]      s1_col;
    logic [ROW_W-1:0]      s1_row;

    // Stage 2: sector count and raw magnitude.
    logic [2:0]       k_next;
    logic [RAW_W-1:0] raw_next;
    logic [PROD_W-1:0] lhs;
    logic [DATA_WIDTH-1:0] mx, mn;

    always_comb begin
        k_next = '0;
        lhs    = PROD_W'({s1_ay, 8'd0});
        for (int unsigned i = 0; i < 4; i++) begin
            if (lhs >= PROD_W'(s1_ax) * PROD_W'(TAN_Q8[i])) k_next = k_next + 3'd1;
        end
        // A zero vector meets every threshold; pin it to bin 0.
        if (s1_ax == '0 && s1_ay == '0) k_next = '0;

        mx = (s1_ax >= s1_ay) ? s1_ax : s1_ay;
        mn = (s1_ax >= s1_ay) ? s1_ay : s1_ax;
        if (MAG_MODE == 0) raw_next = RAW_W'(s1_ax) + RAW_W'(s1_ay);
        else               raw_next = RAW_W'(mx) + RAW_W'(mn >> 1);
    end

    logic             s2_valid, s2_smode;
    logic [2:0]       s2_k;
    logic [RAW_W-1:0] s2_raw;
    quad_t            s2_quad;
    logic [COL_W-1:0] s2_col;
    logic [ROW_W-1:0] s2_row;

    // Stage 3: bin mapping and magnitude saturation.
    logic [4:0]           bin_next;
    logic [4:0]           k5;
    logic [SAT_W-1:0]     raw_ext;
    logic [MAG_WIDTH-1:0] mag_next;

    always_comb begin
        k5 = {2'b00, s2_k};
        bin_next = k5;
        case (s2_quad)
            Q_I:   bin_next = k5;
            Q_II:  bin_next = 5'd8 - k5;
            Q_III: bin_next = s2_smode ? 5'd9 + k5 : k5;
            Q_IV:  bin_next = s2_smode ? 5'd17 - k5 : 5'd8 - k5;
            default: bin_next = k5;
        endcase

        raw_ext = SAT_W'(s2_raw);
        if (raw_ext > SAT_W'({MAG_WIDTH{1'b1}})) mag_next = '1;
        else                                      mag_next = raw_ext[MAG_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid   <= 1'b0;
            s1_smode   <= 1'b0;
            s1_ax      <= '0;
            s1_ay      <= '0;
            s1_quad    <= Q_I;
            s1_col     <= '0;
            s1_row     <= '0;
            s2_valid   <= 1'b0;
            s2_smode   <= 1'b0;
            s2_k       <= '0;
            s2_raw     <= '0;
            s2_quad    <= Q_I;
            s2_col     <= '0;
            s2_row     <= '0;
            vote_valid <= 1'b0;
            magnitude  <= '0;
            bin        <= '0;
            col        <= '0;
            row        <= '0;
            sof        <= 1'b0;
            eol        <= 1'b0;
        end else if (advance) begin
            s1_valid   <= grad_valid;
            s1_smode   <= signed_mode;
            s1_ax      <= sat_abs(gx);
            s1_ay      <= sat_abs(gy);
            s1_quad    <= quad_in;
            s1_col     <= pos_col;
            s1_row     <= pos_row;

            s2_valid   <= s1_valid;
            s2_smode   <= s1_smode;
            s2_k       <= k_next;
            s2_raw     <= raw_next;
            s2_quad    <= s1_quad;
            s2_col     <= s1_col;
            s2_row     <= s1_row;

            vote_valid <= s2_valid;
            magnitude  <= mag_next;
            bin        <= bin_next;
            col        <= s2_col;
            row        <= s2_row;
            sof        <= (s2_col == '0) && (s2_row == '0);
            eol        <= (s2_col == COL_W'(GRID_WIDTH - 1));
        end
    end

endmodule

// File: tb/tb_hog_bin_pipe.sv
// tb_hog_bin_pipe: directed bench for hog_bin_pipe. Two instances share the
// stimulus (L1 and max+min/2 magnitude) on a 4x2 grid. A queue model predicts
// every output beat; directed beats also carry literal expectations.
module tb_hog_bin_pipe;

    localparam int DW = 8;
    localparam int MW = 8;
    localparam int GW = 4;
    localparam int GH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          grad_valid = 1'b0;
    logic          vote_ready = 1'b1;
    logic          signed_mode = 1'b0;
    logic [DW:0]   gx = '0;
    logic [DW:0]   gy = '0;

    logic          grad_ready_a, vote_valid_a, sof_a, eol_a;
    logic [MW-1:0] magnitude_a;
    logic [4:0]    bin_a;
    logic [1:0]    col_a;
    logic [0:0]    row_a;

    logic          grad_ready_b, vote_valid_b, sof_b, eol_b;
    logic [MW-1:0] magnitude_b;
    logic [4:0]    bin_b;
    logic [1:0]    col_b;
    logic [0:0]    row_b;

    hog_bin_pipe #(.DATA_WIDTH(DW), .MAG_WIDTH(MW), .MAG_MODE(0),
                   .GRID_WIDTH(GW), .GRID_HEIGHT(GH)) dut_a (
        .clk(clk), .rst(rst), .grad_valid(grad_valid), .grad_ready(grad_ready_a),
        .gx(gx), .gy(gy), .signed_mode(signed_mode),
        .vote_valid(vote_valid_a), .vote_ready(vote_ready),
        .magnitude(magnitude_a), .bin(bin_a), .col(col_a), .row(row_a),
        .sof(sof_a), .eol(eol_a));

    hog_bin_pipe #(.DATA_WIDTH(DW), .MAG_WIDTH(MW), .MAG_MODE(1),
                   .GRID_WIDTH(GW), .GRID_HEIGHT(GH)) dut_b (
        .clk(clk), .rst(rst), .grad_valid(grad_valid), .grad_ready(grad_ready_b),
        .gx(gx), .gy(gy), .signed_mode(signed_mode),
        .vote_valid(vote_valid_b), .vote_ready(vote_ready),
        .magnitude(magnitude_b), .bin(bin_b), .col(col_b), .row(row_b),
        .sof(sof_b), .eol(eol_b));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int unsigned mag_a, mag_b, bin, col, row, sof, eol, adv;
    } beat_t;

    beat_t q[$];
    int unsigned m_col = 0, m_row = 0;
    int out_idx = 0;
    int unsigned obs_col[0:31], obs_row[0:31], obs_sof[0:31], obs_eol[0:31];

    function automatic int unsigned m_abs(input int v);
        if (v >= 0) return v;
        if (-v > 255) return 255;
        return -v;
    endfunction

    function automatic int unsigned m_bin(input int x, input int y, input bit sm);
        int unsigned ax, ay, k, fold;
        int t[4];
        bit upper;
        t = '{93, 215, 443, 1452};
        ax = m_abs(x);
        ay = m_abs(y);
        if (ax == 0 && ay == 0) return 0;
        k = 0;
        for (int i = 0; i < 4; i++) if (ay * 256 >= ax * t[i]) k++;
        // upper half-plane covers [0,180) degrees
        upper = (y > 0) || (y == 0 && x >= 0);
        if (upper) fold = (x >= 0) ? k : 8 - k;
        else       fold = (x < 0)  ? k : 8 - k;
        if (!upper && sm) fold += 9;
        return fold;
    endfunction

    function automatic int unsigned sat8(input int unsigned v);
        return (v > 255) ? 255 : v;
    endfunction

    always @(negedge clk) begin
        bit exp_valid, stall_m;
        beat_t nb;
        int sx, sy;
        if (!rst) begin
            q.delete();
            m_col = 0;
            m_row = 0;
            out_idx = 0;
            check("rst_vote_valid_a", vote_valid_a, 0);
            check("rst_vote_valid_b", vote_valid_b, 0);
            check("rst_magnitude", magnitude_a, 0);
            check("rst_bin", bin_a, 0);
            check("rst_col", col_a, 0);
            check("rst_row", row_a, 0);
            check("rst_sof", sof_a, 0);
            check("rst_eol", eol_a, 0);
        end else begin
            exp_valid = (q.size() > 0) && (q[0].adv >= 3);
            check("vote_valid_a", vote_valid_a, exp_valid);
            check("vote_valid_b", vote_valid_b, exp_valid);
            if (exp_valid) begin
                check("mag_a", magnitude_a, q[0].mag_a);
                check("mag_b", magnitude_b, q[0].mag_b);
                check("bin_a", bin_a, q[0].bin);
                check("bin_b", bin_b, q[0].bin);
                check("col", col_a, q[0].col);
                check("row", row_a, q[0].row);
                check("sof", sof_a, q[0].sof);
                check("eol", eol_a, q[0].eol);
            end
            stall_m = exp_valid && !vote_ready;
            check("grad_ready_a", grad_ready_a, !stall_m);
            check("grad_ready_b", grad_ready_b, !stall_m);
            if (!stall_m) begin
                if (exp_valid) begin
                    if (out_idx < 32) begin
                        obs_col[out_idx] = col_a;
                        obs_row[out_idx] = row_a;
                        obs_sof[out_idx] = sof_a;
                        obs_eol[out_idx] = eol_a;
                    end
                    out_idx++;
                    void'(q.pop_front());
                end
                foreach (q[i]) q[i].adv++;
                if (grad_valid) begin
                    sx = $signed(gx);
                    sy = $signed(gy);
                    nb.mag_a = sat8(m_abs(sx) + m_abs(sy));
                    nb.mag_b = sat8((m_abs(sx) > m_abs(sy)) ?
                                    m_abs(sx) + m_abs(sy) / 2 : m_abs(sy) + m_abs(sx) / 2);
                    nb.bin = m_bin(sx, sy, signed_mode);
                    nb.col = m_col;
                    nb.row = m_row;
                    nb.sof = (m_col == 0 && m_row == 0);
                    nb.eol = (m_col == GW - 1);
                    nb.adv = 1;
                    q.push_back(nb);
                    m_col++;
                    if (m_col == GW) begin
                        m_col = 0;
                        m_row = (m_row + 1) % GH;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_one(input string name, input int x, input int y, input bit sm,
                            input int exp_bin, input int exp_ma, input int exp_mb);
        int lat;
        @(posedge clk); #2;
        gx = x[DW:0];
        gy = y[DW:0];
        signed_mode = sm;
        grad_valid = 1'b1;
        vote_ready = 1'b1;
        @(posedge clk); #2;
        grad_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (vote_valid_a) begin
                lat = n;
                break;
            end
        end
        check({name, "_latency"}, lat, 3);
        check({name, "_bin"}, bin_a, exp_bin);
        check({name, "_mag_l1"}, magnitude_a, exp_ma);
        check({name, "_mag_maxmin"}, magnitude_b, exp_mb);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        grad_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
    endtask

    initial begin
        int sent, cyc;
        bit acc;

        // reset held with valid asserted
        #1;
        rst = 1'b0;
        grad_valid = 1'b1;
        gx = 9'd5;
        gy = 9'd3;
        repeat (3) @(posedge clk);
        #2;
        grad_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", grad_ready_a, 1);

        // unsigned orientation
        send_one("u_10_0",    10,   0, 0, 0, 10, 10);
        send_one("u_m10_10", -10,  10, 0, 6, 20, 15);
        send_one("u_m10_m10",-10, -10, 0, 2, 20, 15);
        send_one("u_0_10",     0,  10, 0, 4, 10, 10);
        // signed orientation
        send_one("s_m10_m10",-10, -10, 1, 11, 20, 15);
        send_one("s_10_m10",  10, -10, 1, 15, 20, 15);
        send_one("s_m10_0",  -10,   0, 1, 9, 10, 10);
        // magnitude
        send_one("m_10_m4",   10,  -4, 0, 7, 14, 12);
        send_one("m_255_255",255, 255, 0, 2, 255, 255);
        send_one("m_m256_0",-256,   0, 0, 0, 255, 255);
        send_one("m_0_0",      0,   0, 1, 0, 0, 0);

        // reset with beats in flight
        @(posedge clk); #2;
        gx = 9'd20; gy = 9'd7; grad_valid = 1'b1;
        @(posedge clk); #2;
        gx = 9'd3;
        pulse_reset();
        repeat (5) @(posedge clk);

        // backpressure: 20 random beats, vote_ready 1-0-0
        sent = 0;
        cyc = 0;
        acc = 1'b0;
        @(posedge clk); #2;
        gx = 9'($urandom_range(0, 511));
        gy = 9'($urandom_range(0, 511));
        signed_mode = 1'($urandom_range(0, 1));
        grad_valid = 1'b1;
        vote_ready = 1'b1;
        #1 acc = grad_ready_a;
        while (sent < 20 && cyc < 300) begin
            @(posedge clk); #2;
            if (acc) begin
                sent++;
                gx = 9'($urandom_range(0, 511));
                gy = 9'($urandom_range(0, 511));
                signed_mode = 1'($urandom_range(0, 1));
            end
            cyc++;
            vote_ready = (cyc % 3 == 0);
            grad_valid = (sent < 20);
            #1 acc = grad_valid && grad_ready_a;
        end
        check("bp_all_accepted", sent, 20);
        for (int n = 0; n < 100 && q.size() > 0; n++) begin
            @(posedge clk); #2;
            cyc++;
            vote_ready = (cyc % 3 == 0);
        end
        @(negedge clk);
        check("bp_drained", q.size(), 0);

        // position tracking over 9 beats on the 4x2 grid
        pulse_reset();
        vote_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #2;
            gx = 9'(i + 1);
            gy = 9'd2;
            signed_mode = 1'b0;
            grad_valid = 1'b1;
        end
        @(posedge clk); #2;
        grad_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("pos_count", out_idx, 9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("pos_col_%0d", i), obs_col[i], i % 4);
            check($sformatf("pos_row_%0d", i), obs_row[i], (i / 4) % 2);
            check($sformatf("pos_sof_%0d", i), obs_sof[i], (i == 0 || i == 8) ? 1 : 0);
            check($sformatf("pos_eol_%0d", i), obs_eol[i], (i == 3 || i == 7) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
